// File: rtl/branch_ctrl.sv
// EX-stage branch resolution, 2-bit BHT prediction and
// registered one-cycle redirect/flush with statistics.
module branch_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_taken,
  input  logic             i_stall,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_is_slt,
  input  logic             i_ex_slt_imm,
  input  logic             i_ex_slt_un,
  input  logic [2:0]       i_ex_funct3,
  input  logic [31:0]      i_ex_pc,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_br_un,
  output logic             o_slti_sel,
  output logic             o_slt_result,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam int N = 1 << IDX_W;

  typedef enum logic {
    NORMAL,
    REDIRECT
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       bht [N];
  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;
  logic [1:0]       ent_ex;
  logic             ex_v;
  logic             legal;
  logic             taken;
  logic             upd;
  logic             miss;
  logic             redirect_nxt;
  logic [31:0]      pc_nxt;
  logic             unused;

  assign unused = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  assign idx_if       = i_if_pc[IDX_W+1:2];
  assign idx_ex       = i_ex_pc[IDX_W+1:2];
  assign ent_ex       = bht[idx_ex];
  assign o_pred_taken = bht[idx_if][1];

  assign o_br_un = i_ex_is_branch ? i_ex_funct3[1]
                                  : (i_ex_is_slt & i_ex_slt_un);
  assign o_slti_sel   = ~i_ex_is_branch & i_ex_is_slt & i_ex_slt_imm;
  assign o_slt_result = i_ex_is_slt & i_br_less;

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (i_ex_funct3)
      3'b000:          taken = i_br_equal;
      3'b001:          taken = ~i_br_equal;
      3'b100, 3'b110:  taken = i_br_less;
      3'b101, 3'b111:  taken = ~i_br_less;
      default:         legal = 1'b0;
    endcase
  end

  assign ex_v = i_ex_valid & ~i_stall & (state == NORMAL);
  assign upd  = ex_v & i_ex_is_branch & legal;
  assign miss = upd & (taken != i_ex_pred_taken);

  always_comb begin
    state_nxt    = state;
    redirect_nxt = 1'b0;
    pc_nxt       = o_redirect_pc;
    case (state)
      NORMAL: begin
        if (miss) begin
          state_nxt    = REDIRECT;
          redirect_nxt = 1'b1;
          pc_nxt       = taken ? i_ex_target : i_ex_pc + 32'd4;
        end
      end
      REDIRECT: state_nxt = NORMAL;
      default:  state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= NORMAL;
      o_redirect    <= 1'b0;
      o_flush       <= 1'b0;
      o_redirect_pc <= 32'd0;
    end else begin
      state         <= state_nxt;
      o_redirect    <= redirect_nxt;
      o_flush       <= redirect_nxt;
      o_redirect_pc <= pc_nxt;
    end
  end

  // Entries start weakly not-taken and saturate at both ends.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (upd) begin
      if (taken && ent_ex != 2'b11) begin
        bht[idx_ex] <= ent_ex + 2'b01;
      end else if (!taken && ent_ex != 2'b00) begin
        bht[idx_ex] <= ent_ex - 2'b01;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_br_cnt   <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (upd && !(&o_br_cnt)) begin
        o_br_cnt <= o_br_cnt + 1'b1;
      end
      if (miss && !(&o_miss_cnt)) begin
        o_miss_cnt <= o_miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: model predicts next-cycle
// registered outputs, which are popped and compared after each edge.
module tb_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        stall;
  logic        ex_valid;
  logic        is_branch;
  logic        is_slt;
  logic        slt_imm;
  logic        slt_un;
  logic [2:0]  funct3;
  logic [31:0] ex_pc;
  logic [31:0] target;
  logic        ex_pred;
  logic        less;
  logic        equal;
  logic        br_un;
  logic        slti_sel;
  logic        slt_result;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] br_cnt;
  logic [15:0] miss_cnt;

  logic        pred_taken2;
  logic        br_un2;
  logic        slti_sel2;
  logic        slt_result2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        flush2;
  logic [1:0]  br_cnt2;
  logic [1:0]  miss_cnt2;

  branch_ctrl #(.IDX_W(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_taken(pred_taken), .i_stall(stall),
    .i_ex_valid(ex_valid), .i_ex_is_branch(is_branch),
    .i_ex_is_slt(is_slt), .i_ex_slt_imm(slt_imm),
    .i_ex_slt_un(slt_un), .i_ex_funct3(funct3),
    .i_ex_pc(ex_pc), .i_ex_target(target),
    .i_ex_pred_taken(ex_pred), .i_br_less(less),
    .i_br_equal(equal), .o_br_un(br_un),
    .o_slti_sel(slti_sel), .o_slt_result(slt_result),
    .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_flush(flush), .o_br_cnt(br_cnt), .o_miss_cnt(miss_cnt)
  );

  branch_ctrl #(.IDX_W(4), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_taken(pred_taken2), .i_stall(stall),
    .i_ex_valid(ex_valid), .i_ex_is_branch(is_branch),
    .i_ex_is_slt(is_slt), .i_ex_slt_imm(slt_imm),
    .i_ex_slt_un(slt_un), .i_ex_funct3(funct3),
    .i_ex_pc(ex_pc), .i_ex_target(target),
    .i_ex_pred_taken(ex_pred), .i_br_less(less),
    .i_br_equal(equal), .o_br_un(br_un2),
    .o_slti_sel(slti_sel2), .o_slt_result(slt_result2),
    .o_redirect(redirect2), .o_redirect_pc(redirect_pc2),
    .o_flush(flush2), .o_br_cnt(br_cnt2), .o_miss_cnt(miss_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] pc;
    int          br;
    int          miss;
    int          br2;
    int          miss2;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  m_bht[16];
  logic        m_state;
  logic        m_init;
  logic [31:0] m_pc;
  int          m_br, m_miss, m_br2, m_miss2;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    is_branch = 1'b0;
    is_slt    = 1'b0;
    slt_imm   = 1'b0;
    slt_un    = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc,
                    input logic [31:0] tgt, input logic eq,
                    input logic lt, input logic p);
    idle();
    ex_valid  = 1'b1;
    is_branch = 1'b1;
    funct3    = f3;
    ex_pc     = pc;
    target    = tgt;
    equal     = eq;
    less      = lt;
    ex_pred   = p;
  endtask

  task automatic cycle();
    exp_t e, r;
    logic lg, tk, exv, upd, ms;
    logic [3:0] ix;
    #1;
    check("br_un", br_un,
          is_branch ? funct3[1] : (is_slt & slt_un));
    check("slti_sel", slti_sel, !is_branch && is_slt && slt_imm);
    check("slt_result", slt_result, is_slt & less);
    if (m_init) check("pred", pred_taken, m_bht[if_pc[5:2]][1]);
    lg = 1'b1;
    tk = 1'b0;
    case (funct3)
      3'd0: tk = equal;
      3'd1: tk = !equal;
      3'd4, 3'd6: tk = less;
      3'd5, 3'd7: tk = !less;
      default: lg = 1'b0;
    endcase
    exv = ex_valid && !stall && !m_state;
    upd = exv && is_branch && lg;
    ms  = upd && (tk != ex_pred);
    ix  = ex_pc[5:2];
    e.rd = 1'b0;
    if (!rst_n) begin
      m_state = 1'b0;
      m_pc    = 32'd0;
      m_br = 0; m_miss = 0; m_br2 = 0; m_miss2 = 0;
      for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
      m_init = 1'b1;
    end else begin
      if (upd) begin
        if (m_br < 65535) m_br++;
        if (m_br2 < 3) m_br2++;
        if (tk && m_bht[ix] != 2'b11) m_bht[ix]++;
        if (!tk && m_bht[ix] != 2'b00) m_bht[ix]--;
      end
      if (ms) begin
        if (m_miss < 65535) m_miss++;
        if (m_miss2 < 3) m_miss2++;
        e.rd = 1'b1;
        m_pc = tk ? target : ex_pc + 32'd4;
      end
      m_state = ms;
    end
    e.pc = m_pc;
    e.br = m_br; e.miss = m_miss; e.br2 = m_br2; e.miss2 = m_miss2;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      r = q.pop_front();
      check("redirect", redirect, r.rd);
      check("flush", flush, r.rd);
      if (r.rd) check("redirect_pc", redirect_pc, r.pc);
      check("br_cnt", br_cnt, r.br);
      check("miss_cnt", miss_cnt, r.miss);
      check("br_cnt2", br_cnt2, r.br2);
      check("miss_cnt2", miss_cnt2, r.miss2);
    end
  endtask

  initial begin
    m_init = 1'b0;
    m_state = 1'b0;
    m_pc = 32'd0;
    m_br = 0; m_miss = 0; m_br2 = 0; m_miss2 = 0;
    rst_n = 1'b0;
    if_pc = 32'd0;
    funct3 = 3'd0;
    ex_pc = 32'd0;
    target = 32'd0;
    ex_pred = 1'b0;
    less = 1'b0;
    equal = 1'b0;
    idle();
    @(posedge clk);
    #2;
    cycle();
    cycle();
    check("rst_redirect_pc", redirect_pc, 32'd0);
    rst_n = 1'b1;

    if_pc = 32'h40;
    #1;
    check("reset_pred", pred_taken, 1'b0);
    check("reset_bht0", dut.bht[0], 2'b01);
    cycle();

    br(3'b000, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    cycle();
    check("beq_redirect", redirect, 1'b1);
    check("beq_pc", redirect_pc, 32'h80);
    idle();
    cycle();
    check("beq_after", redirect, 1'b0);
    check("beq_br_cnt", br_cnt, 16'd1);
    check("beq_miss_cnt", miss_cnt, 16'd1);

    check("bht15_init", dut.bht[15], 2'b01);
    br(3'b111, 32'h3C, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bgeu_un", br_un, 1'b1);
      cycle();
      check("bht15", dut.bht[15], 2'b00);
    end
    br(3'b000, 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b0, 1'b1);
    cycle();
    check("wrap_pc", redirect_pc, 32'h0);
    idle();
    cycle();

    idle();
    ex_valid = 1'b1;
    is_slt = 1'b1;
    slt_imm = 1'b1;
    less = 1'b1;
    #1;
    check("slti_sel_ex", slti_sel, 1'b1);
    check("slti_un_ex", br_un, 1'b0);
    check("slti_res_ex", slt_result, 1'b1);
    cycle();

    br(3'b001, 32'h50, 32'h200, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    cycle();
    cycle();
    check("stall_hold", redirect, 1'b0);
    stall = 1'b0;
    cycle();
    check("stall_release", redirect, 1'b1);
    br(3'b000, 32'h60, 32'h300, 1'b1, 1'b0, 1'b0);
    cycle();
    check("wrong_path", redirect, 1'b0);
    idle();
    cycle();

    br(3'b100, 32'h70, 32'h400, 1'b0, 1'b1, 1'b0);
    cycle();
    rst_n = 1'b0;
    cycle();
    check("rst_mid_redirect", redirect, 1'b0);
    check("rst_mid_flush", flush, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      br(3'b000, 32'h10, 32'h500, 1'b1, 1'b0, 1'b0);
      cycle();
      idle();
      cycle();
    end
    check("miss_sat", miss_cnt2, 2'd3);
    cycle();
    check("miss_sat_hold", miss_cnt2, 2'd3);

    for (int i = 0; i < 80; i++) begin
      ex_valid  = ($urandom_range(3) != 0);
      is_branch = $urandom_range(1);
      is_slt    = $urandom_range(1);
      slt_imm   = $urandom_range(1);
      slt_un    = $urandom_range(1);
      stall     = ($urandom_range(4) == 0);
      funct3    = 3'($urandom_range(7));
      ex_pc     = {$urandom_range(255), 2'b00};
      target    = $urandom;
      ex_pred   = $urandom_range(1);
      less      = $urandom_range(1);
      equal     = $urandom_range(1);
      if_pc     = {$urandom_range(255), 2'b00};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
